// File: rtl/motoro3_deadtime_guard_if.sv
// Gate request/drive bundle of the 3-phase dead-time guard.
// master = request source (sine generators, control); slave = the guard itself.
interface motoro3_deadtime_guard_if #(
   parameter int unsigned CONF_W = 8
);
   logic              aHpIn, aLpIn, bHpIn, bLpIn, cHpIn, cLpIn;
   logic              gEn, ocFault, faultClr;
   logic              aHo, aLo, bHo, bLo, cHo, cLo;
   logic              faultLatched;
   logic [CONF_W-1:0] m3conflictCnt;

   modport master (
      output aHpIn, aLpIn, bHpIn, bLpIn, cHpIn, cLpIn, gEn, ocFault, faultClr,
      input  aHo, aLo, bHo, bLo, cHo, cLo, faultLatched, m3conflictCnt
   );

   modport slave (
      input  aHpIn, aLpIn, bHpIn, bLpIn, cHpIn, cLpIn, gEn, ocFault, faultClr,
      output aHo, aLo, bHo, bLo, cHo, cLo, faultLatched, m3conflictCnt
   );
endinterface

// File: rtl/motoro3_deadtime_guard.sv
// 3-phase gate guard: dead-time gap, shoot-through removal, conflict count, enable/over-current kill.
// Define M3_FAULT_LATCH_EN to hold an over-current fault until faultClr.
module motoro3_deadtime_guard #(
   parameter int unsigned DEADTIME = 20,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned CONF_W   = 8
) (
   input  logic                    clk,
   input  logic                    nRst,
   motoro3_deadtime_guard_if.slave gd
);
   typedef enum logic [1:0] {OFF = 2'd0, H_ON = 2'd1, L_ON = 2'd2} phaseState_t;

   localparam logic [CNT_W-1:0] DT_SAT = CNT_W'(DEADTIME);

   logic [2:0]        hReq, lReq, wantH, wantL, bothReq, prevBoth, bothRise;
   logic [2:0]        hOut, lOut;
   logic [1:0]        riseSum;
   logic [CONF_W:0]   confSum;
   logic [CONF_W-1:0] conflictCnt;
   logic [CNT_W-1:0]  dtCnt [3];
   phaseState_t       state [3];
   phaseState_t       nextState [3];
   logic              faultQ;
   logic              kill;

   assign hReq     = {gd.cHpIn, gd.bHpIn, gd.aHpIn};
   assign lReq     = {gd.cLpIn, gd.bLpIn, gd.aLpIn};
   assign wantH    = hReq & ~lReq;
   assign wantL    = lReq & ~hReq;
   assign bothReq  = hReq & lReq;
   assign bothRise = bothReq & ~prevBoth;

`ifdef M3_FAULT_LATCH_EN
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         faultQ <= 1'b0;
      end else if (gd.ocFault) begin
         faultQ <= 1'b1;
      end else if (gd.faultClr) begin
         faultQ <= 1'b0;
      end
   end

   assign kill = !gd.gEn || faultQ || gd.ocFault;
`else
   logic unusedFaultClr;
   assign unusedFaultClr = gd.faultClr;
   assign faultQ         = 1'b0;
   assign kill           = !gd.gEn || gd.ocFault;
`endif

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         nextState[i] = state[i];
         case (state[i])
            OFF: begin
               if (!kill && (dtCnt[i] >= DT_SAT)) begin
                  if (wantH[i]) begin
                     nextState[i] = H_ON;
                  end else if (wantL[i]) begin
                     nextState[i] = L_ON;
                  end
               end
            end
            H_ON:    if (kill || !wantH[i]) nextState[i] = OFF;
            L_ON:    if (kill || !wantL[i]) nextState[i] = OFF;
            default: nextState[i] = OFF;
         endcase
      end
   end

   // Counter follows the next state, so the edge a gate falls already counts the first
   // both-low cycle and the next turn-on lands exactly DEADTIME cycles later.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int unsigned i = 0; i < 3; i++) begin
            state[i] <= OFF;
            dtCnt[i] <= '0;
         end
         hOut <= '0;
         lOut <= '0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            state[i] <= nextState[i];
            hOut[i]  <= (nextState[i] == H_ON);
            lOut[i]  <= (nextState[i] == L_ON);
            if (nextState[i] != OFF) begin
               dtCnt[i] <= '0;
            end else if (dtCnt[i] < DT_SAT) begin
               dtCnt[i] <= dtCnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign riseSum = 2'(bothRise[0]) + 2'(bothRise[1]) + 2'(bothRise[2]);
   assign confSum = {1'b0, conflictCnt} + (CONF_W + 1)'(riseSum);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         prevBoth    <= '0;
         conflictCnt <= '0;
      end else begin
         prevBoth    <= bothReq;
         conflictCnt <= confSum[CONF_W] ? '1 : confSum[CONF_W-1:0];
      end
   end

   assign gd.aHo           = hOut[0];
   assign gd.aLo           = lOut[0];
   assign gd.bHo           = hOut[1];
   assign gd.bLo           = lOut[1];
   assign gd.cHo           = hOut[2];
   assign gd.cLo           = lOut[2];
   assign gd.faultLatched  = faultQ;
   assign gd.m3conflictCnt = conflictCnt;
endmodule
